// File: rtl/filter_pkg.sv
// Shared geometry for the 5x5 window stage and the convolution stage behind it.
//   KSIZE        : window edge length
//   NBUF         : number of stored previous lines
//   elem_offset  : bit offset of element (r,c) inside a flattened window
package filter_pkg;

  localparam int unsigned KSIZE = 5;
  localparam int unsigned NBUF  = KSIZE - 1;

  // Bit offset of window element (r,c); r=0 is the top row, c=0 the left column.
  function automatic int elem_offset(input int r, input int c, input int dw);
    return (int'(KSIZE) * r + c) * dw;
  endfunction

endpackage

// File: rtl/filter_window_5x5_if.sv
// Pixel-stream in / window out bundle of the 5x5 window generator.
//   i_valid, i_sof, i_data : raster pixel stream from the producer
//   o_valid, o_win, o_last : registered window toward the convolution stage
//   master : producer/consumer side (testbench or upstream logic)
//   slave  : the window generator itself
interface filter_window_5x5_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  import filter_pkg::*;

  logic                                  i_valid;
  logic                                  i_sof;
  logic [DATA_WIDTH-1:0]                 i_data;
  logic                                  o_valid;
  logic [KSIZE*KSIZE*DATA_WIDTH-1:0]     o_win;
  logic                                  o_last;

  modport master (
    output i_valid, i_sof, i_data,
    input  o_valid, o_win, o_last
  );

  modport slave (
    input  i_valid, i_sof, i_data,
    output o_valid, o_win, o_last
  );

endinterface

// File: rtl/filter_line_buffer.sv
// One image line of storage, indexed by column.
//   clk     : clock
//   we      : write enable (accepted pixel)
//   addr    : column address, shared by read and write
//   wdata   : value stored at addr on the rising edge
//   rdata_c : combinational read of addr; returns the value before this cycle's write
// Contents are intentionally not reset.
module filter_line_buffer #(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 64,
  localparam int unsigned AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata_c
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata_c = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/filter_window_5x5.sv
// Raster-stream to 5x5 neighbourhood window generator.
//   clk  : clock, all logic on rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of filter_window_5x5_if
//          in : i_valid, i_sof, i_data
//          out: o_valid (one pulse per interior window, latency 1),
//               o_win (element (r,c) at elem_offset(r,c)), o_last (final window of frame)
// Only fully-interior windows are flagged; there is no border padding.
module filter_window_5x5
  import filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 64,
  parameter int unsigned IMG_HEIGHT = 64
) (
  input  logic              clk,
  input  logic              rst,
  filter_window_5x5_if.slave bus
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned RW = $clog2(IMG_HEIGHT);

  logic [CW-1:0]         col, pos_col, col_nxt;
  logic [RW-1:0]         row, pos_row, row_nxt;
  logic                  accept;
  logic                  win_done;
  logic                  frame_end;
  logic [DATA_WIDTH-1:0] rd     [NBUF];
  logic [DATA_WIDTH-1:0] colvec [KSIZE];
  logic [DATA_WIDTH-1:0] win    [KSIZE][KSIZE];

  // Position of the pixel being accepted; a start-of-frame overrides the counters.
  always_comb begin
    accept   = bus.i_valid;
    pos_col  = bus.i_sof ? '0 : col;
    pos_row  = bus.i_sof ? '0 : row;
    col_nxt  = pos_col;
    row_nxt  = pos_row;
    if (pos_col == CW'(IMG_WIDTH - 1)) begin
      col_nxt = '0;
      row_nxt = (pos_row == RW'(IMG_HEIGHT - 1)) ? '0 : pos_row + RW'(1);
    end else begin
      col_nxt = pos_col + CW'(1);
    end
    // Window is complete only once four earlier rows and columns of this frame/line exist.
    win_done  = (pos_row >= RW'(KSIZE - 1)) && (pos_col >= CW'(KSIZE - 1));
    frame_end = win_done && (pos_row == RW'(IMG_HEIGHT - 1)) &&
                (pos_col == CW'(IMG_WIDTH - 1));
  end

  // Line buffers form a vertical shift chain: line k+1 takes what line k held at this column.
  for (genvar k = 0; k < int'(NBUF); k++) begin : g_line
    logic [DATA_WIDTH-1:0] wdata;
    if (k == 0) begin : g_head
      assign wdata = bus.i_data;
    end else begin : g_tail
      assign wdata = rd[k-1];
    end
    filter_line_buffer #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (IMG_WIDTH)
    ) u_line (
      .clk     (clk),
      .we      (accept),
      .addr    (pos_col),
      .wdata   (wdata),
      .rdata_c (rd[k])
    );
  end

  // Current column, top (oldest line) to bottom (incoming pixel).
  always_comb begin
    for (int r = 0; r < int'(NBUF); r++) colvec[r] = rd[int'(NBUF) - 1 - r];
    colvec[KSIZE-1] = bus.i_data;
  end

  // Window shift registers and output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      bus.o_valid <= 1'b0;
      bus.o_last  <= 1'b0;
      for (int r = 0; r < int'(KSIZE); r++)
        for (int c = 0; c < int'(KSIZE); c++)
          win[r][c] <= '0;
    end else begin
      bus.o_valid <= accept && win_done;
      bus.o_last  <= accept && frame_end;
      if (accept) begin
        col <= col_nxt;
        row <= row_nxt;
        for (int r = 0; r < int'(KSIZE); r++) begin
          for (int c = 0; c < int'(KSIZE) - 1; c++)
            win[r][c] <= win[r][c+1];
          win[r][KSIZE-1] <= colvec[r];
        end
      end
    end
  end

  // Flatten the window registers onto the output bus.
  for (genvar r = 0; r < int'(KSIZE); r++) begin : g_out_r
    for (genvar c = 0; c < int'(KSIZE); c++) begin : g_out_c
      assign bus.o_win[elem_offset(r, c, int'(DATA_WIDTH)) +: DATA_WIDTH] = win[r][c];
    end
  end

endmodule

// File: tb/tb_filter_window_5x5.sv
// Self-checking bench for filter_window_5x5 (8x8 image, 8-bit pixels).
// Reference model: the accepted pixels of the current frame are stored in an
// image array at their raster position; every expected window is cut out of it.
module tb_filter_window_5x5;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 8;
  localparam int unsigned WB = 25 * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_window_5x5_if #(.DATA_WIDTH(DW)) bus ();

  filter_window_5x5 #(
    .DATA_WIDTH (DW),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] img [H][W];
  int            n_pos;
  int            n_checks = 0;
  int            n_fail   = 0;
  int            pulses;
  int            px_cnt;
  int            first_px;
  logic [WB-1:0] wins[$];
  logic [WB-1:0] ref_wins[$];

  function automatic logic [DW-1:0] elem(input logic [WB-1:0] w, input int r, input int c);
    return w[(5*r+c)*DW +: DW];
  endfunction

  task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one accepted pixel, update the model, then check the registered outputs.
  task automatic push(input logic sof, input logic [DW-1:0] d);
    int r, c;
    logic ev, el;
    logic [WB-1:0] ew;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_sof   = sof;
    bus.i_data  = d;
    if (sof) n_pos = 0;
    r = n_pos / W;
    c = n_pos % W;
    img[r][c] = d;
    ev = (r >= 4) && (c >= 4);
    el = ev && (r == H-1) && (c == W-1);
    ew = '0;
    if (ev)
      for (int rr = 0; rr < 5; rr++)
        for (int cc = 0; cc < 5; cc++)
          ew[(5*rr+cc)*DW +: DW] = img[r-4+rr][c-4+cc];
    n_pos = (n_pos + 1) % (W*H);
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    check("o_valid", WB'(bus.o_valid), WB'(ev));
    check("o_last", WB'(bus.o_last), WB'(el));
    if (ev) begin
      check("o_win", bus.o_win, ew);
      if (first_px < 0) first_px = px_cnt;
      pulses++;
      wins.push_back(bus.o_win);
    end
    px_cnt++;
  endtask

  // Idle cycles, optionally with a stray i_sof that must be ignored.
  task automatic idle(input int n, input bit noisy);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_sof   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.i_data  = DW'($urandom);
      @(posedge clk);
      #1;
      check("idle_o_valid", WB'(bus.o_valid), WB'(0));
      check("idle_o_last", WB'(bus.o_last), WB'(0));
    end
    bus.i_sof = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      check("rst_o_valid", WB'(bus.o_valid), WB'(0));
      check("rst_o_last", WB'(bus.o_last), WB'(0));
      check("rst_o_win", bus.o_win, WB'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    n_pos = 0;
  endtask

  task automatic start_scenario();
    pulses   = 0;
    px_cnt   = 0;
    first_px = -1;
    wins.delete();
  endtask

  task automatic frame(input int base, input bit gaps);
    for (int i = 0; i < int'(W*H); i++) begin
      push(i == 0, DW'(base + i));
      if (gaps) idle(1, 1'b0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sof   = 1'b0;
    bus.i_data  = '0;
    n_pos       = 0;
    do_reset(2);

    // 1: continuous frame
    start_scenario();
    frame(0, 1'b0);
    check("s1_pulses", WB'(pulses), WB'(16));
    check("s1_first_px", WB'(first_px), WB'(36));
    check("s1_w0_e00", WB'(elem(wins[0], 0, 0)), WB'(0));
    check("s1_w0_e22", WB'(elem(wins[0], 2, 2)), WB'(18));
    check("s1_w0_e44", WB'(elem(wins[0], 4, 4)), WB'(36));
    check("s1_w4_e00", WB'(elem(wins[4], 0, 0)), WB'(8));
    check("s6_w15_e44", WB'(elem(wins[15], 4, 4)), WB'(63));
    check("s6_w15_e00", WB'(elem(wins[15], 0, 0)), WB'(27));
    ref_wins = wins;

    // 2: same frame with idle cycles between pixels
    start_scenario();
    frame(0, 1'b1);
    check("s2_pulses", WB'(pulses), WB'(16));
    for (int k = 0; k < 16; k++) check("s2_same_win", wins[k], ref_wins[k]);

    // 3: restart on the 21st pixel
    start_scenario();
    for (int i = 0; i < 20; i++) push(i == 0, DW'(i));
    for (int j = 0; j < 36; j++) push(j == 0, DW'(50 + j));
    check("s3_no_early", WB'(pulses), WB'(0));
    push(1'b0, DW'(50 + 36));
    check("s3_first", WB'(pulses), WB'(1));
    check("s3_e44", WB'(elem(wins[0], 4, 4)), WB'(86));

    // 4: reset mid-frame, then a fresh frame
    start_scenario();
    for (int i = 0; i < 41; i++) push(i == 0, DW'(i));
    do_reset(2);
    start_scenario();
    for (int i = 0; i < int'(W*H); i++) push(1'b0, DW'(i));
    check("s4_pulses", WB'(pulses), WB'(16));
    for (int k = 0; k < 16; k++) check("s4_same_win", wins[k], ref_wins[k]);

    // 5: back-to-back frames
    start_scenario();
    frame(0, 1'b0);
    frame(100, 1'b0);
    check("s5_pulses", WB'(pulses), WB'(32));
    check("s5_f2_e00", WB'(elem(wins[16], 0, 0)), WB'(100));
    check("s5_f2_e44", WB'(elem(wins[16], 4, 4)), WB'(136));

    // 7: random data, random gaps, occasional restarts
    start_scenario();
    for (int k = 0; k < 240; k++) begin
      push((k == 0) || ($urandom_range(0, 99) == 0), DW'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
